// File: rtl/uart_transmitter_if.sv
// Parallel-side bus of the UART transmitter: byte/baud request in, serial line and status out.
// The master drives a request; the slave (the transmitter) owns TxD, tx_busy and tx_done.
interface uart_transmitter_if;
    logic [2:0] baudrate_set;
    logic [7:0] TxData;
    logic       tx_start;
    logic       TxD;
    logic       tx_busy;
    logic       tx_done;

    // tx_start is honoured only while tx_busy=0 (a request is taken on the edge that sees it);
    // it is dropped, not queued, while a frame is in flight. tx_done pulses one cycle per frame.
    modport master (
        output baudrate_set, TxData, tx_start,
        input  TxD, tx_busy, tx_done
    );

    modport slave (
        input  baudrate_set, TxData, tx_start,
        output TxD, tx_busy, tx_done
    );
endinterface

// File: rtl/uart_transmitter.sv
// UART transmitter, 8 data bits LSB first, one stop bit, selectable baud rate.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1, 11-bit frame); default build is 8N1.
module uart_transmitter #(
    parameter int clk_freq = 100_000_000
) (
    input  logic                clk,
    input  logic                reset,
    uart_transmitter_if.slave   bus,
    output logic [2:0]          dbg_state
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4
    } state_t;
`endif

    localparam logic [15:0] DIV_2400   = 16'(clk_freq / 2400);
    localparam logic [15:0] DIV_4800   = 16'(clk_freq / 4800);
    localparam logic [15:0] DIV_9600   = 16'(clk_freq / 9600);
    localparam logic [15:0] DIV_19200  = 16'(clk_freq / 19200);
    localparam logic [15:0] DIV_38400  = 16'(clk_freq / 38400);
    localparam logic [15:0] DIV_57600  = 16'(clk_freq / 57600);
    localparam logic [15:0] DIV_115200 = 16'(clk_freq / 115200);
    localparam logic [15:0] DIV_230400 = 16'(clk_freq / 230400);

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [2:0]  idx, idx_n;
    logic [7:0]  data_q, data_n;
    logic [2:0]  baud_q, baud_n;
    logic        txd_q, txd_n;
    logic        busy_q, busy_n;
    logic        done_q, done_n;
    logic [15:0] div;
    logic        bit_end;

    // Divisor comes from the baud code latched at frame start, never the live input.
    always_comb begin
        div = DIV_2400;
        case (baud_q)
            3'd0:    div = DIV_2400;
            3'd1:    div = DIV_4800;
            3'd2:    div = DIV_9600;
            3'd3:    div = DIV_19200;
            3'd4:    div = DIV_38400;
            3'd5:    div = DIV_57600;
            3'd6:    div = DIV_115200;
            default: div = DIV_230400;
        endcase
    end

    assign bit_end = (cnt == div - 16'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            data_q <= '0;
            baud_q <= '0;
            txd_q  <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            data_q <= data_n;
            baud_q <= baud_n;
            txd_q  <= txd_n;
            busy_q <= busy_n;
            done_q <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        data_n  = data_q;
        baud_n  = baud_q;
        txd_n   = txd_q;
        busy_n  = busy_q;
        done_n  = 1'b0;

        // Every non-idle state times one bit period and clears the counter at the boundary.
        if (state != IDLE) begin
            cnt_n = bit_end ? 16'd0 : cnt + 16'd1;
        end

        case (state)
            IDLE: begin
                if (bus.tx_start) begin
                    state_n = START;
                    data_n  = bus.TxData;
                    baud_n  = bus.baudrate_set;
                    cnt_n   = '0;
                    idx_n   = '0;
                    txd_n   = 1'b0;
                    busy_n  = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    txd_n   = data_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
                        txd_n   = ^data_q;
`else
                        state_n = STOP;
                        txd_n   = 1'b1;
`endif
                    end else begin
                        idx_n = idx + 3'd1;
                        txd_n = data_q[idx_n];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_n = STOP;
                    txd_n   = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_n = IDLE;
                    idx_n   = '0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                txd_n   = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

    assign bus.TxD     = txd_q;
    assign bus.tx_busy = busy_q;
    assign bus.tx_done = done_q;
    assign dbg_state   = state;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: table of frames plus hand-written busy/reset/back-to-back sequences.
// Honours UART_TX_PARITY_EN the same way as the design (11-bit frames when defined).
module tb_uart_transmitter;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  typedef struct {
    logic [2:0] baud;
    logic [7:0] data;
    int         period;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] dbg_state;
  int         n_checks = 0;
  int         n_fail = 0;
  int         done_cnt = 0;
  logic       exp_q[$];

  uart_transmitter_if bus ();

  uart_transmitter #(.clk_freq(100_000_000)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock/reset
  always #5 clk = ~clk;

  always @(posedge clk) if (bus.tx_done === 1'b1) done_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected line level for bit b of a frame carrying d.
  function automatic logic frame_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // Called #1 after the edge that starts a bit; returns #1 after the edge that ends it.
  task automatic check_bit(input logic exp, input int period, input string tag);
    check({tag, " first txd"}, 32'(bus.TxD), 32'(exp));
    check({tag, " first busy"}, 32'(bus.tx_busy), 32'd1);
    check({tag, " first done"}, 32'(bus.tx_done), 32'd0);
    repeat (period - 1) @(posedge clk);
    #1;
    check({tag, " last txd"}, 32'(bus.TxD), 32'(exp));
    check({tag, " last busy"}, 32'(bus.tx_busy), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [7:0] d, input int period, input string tag);
    for (int b = 0; b < FRAME_BITS; b++) exp_q.push_back(frame_bit(d, b));
    for (int b = 0; b < FRAME_BITS; b++) begin
      logic e;
      e = exp_q.pop_front();
      check_bit(e, period, $sformatf("%s bit%0d", tag, b));
    end
    check({tag, " done pulse"}, 32'(bus.tx_done), 32'd1);
    check({tag, " done busy"}, 32'(bus.tx_busy), 32'd0);
    check({tag, " done txd"}, 32'(bus.TxD), 32'd1);
    check({tag, " done state"}, 32'(dbg_state), 32'd0);
  endtask

  // driver: request a frame; returns #1 after the accepting edge
  task automatic launch(input logic [7:0] d, input logic [2:0] baud);
    bus.TxData       = d;
    bus.baudrate_set = baud;
    bus.tx_start     = 1'b1;
    @(posedge clk);
    #1;
    bus.tx_start = 1'b0;
  endtask

  // Called #1 after an edge: asserts reset mid-cycle and checks the outputs before any clock.
  task automatic reset_abort(input string tag, input int done_before);
    #3;
    reset = 1'b1;
    #1;
    check({tag, " rst txd"}, 32'(bus.TxD), 32'd1);
    check({tag, " rst busy"}, 32'(bus.tx_busy), 32'd0);
    check({tag, " rst done"}, 32'(bus.tx_done), 32'd0);
    check({tag, " rst state"}, 32'(dbg_state), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check({tag, " post txd"}, 32'(bus.TxD), 32'd1);
    check({tag, " post busy"}, 32'(bus.tx_busy), 32'd0);
    check({tag, " post done count"}, 32'(done_cnt), 32'(done_before));
  endtask

  initial begin
    vec_t vecs[3];
    int   d_before;

    vecs[0] = '{baud: 3'd7, data: 8'hA5, period: 434};
    vecs[1] = '{baud: 3'd7, data: 8'h07, period: 434};
    vecs[2] = '{baud: 3'd7, data: 8'hFF, period: 434};

    reset            = 1'b1;
    bus.tx_start     = 1'b0;
    bus.TxData       = 8'h00;
    bus.baudrate_set = 3'd0;
    #1;
    check("reset txd", 32'(bus.TxD), 32'd1);
    check("reset busy", 32'(bus.tx_busy), 32'd0);
    check("reset done", 32'(bus.tx_done), 32'd0);
    check("reset state", 32'(dbg_state), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("idle txd", 32'(bus.TxD), 32'd1);

    // Table of single frames at 230400 baud
    foreach (vecs[i]) begin
      d_before = done_cnt;
      launch(vecs[i].data, vecs[i].baud);
      run_frame(vecs[i].data, vecs[i].period, $sformatf("vec%0d", i));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d done low", i), 32'(bus.tx_done), 32'd0);
      check($sformatf("vec%0d done count", i), 32'(done_cnt), 32'(d_before + 1));
    end

    // 0x55 at 115200; mid-frame a second request (0xAA) and a baud change to 2400 arrive
    d_before = done_cnt;
    launch(8'h55, 3'd6);
    fork
      run_frame(8'h55, 868, "f55");
      begin
        repeat (1998) @(posedge clk);
        #3;
        bus.TxData       = 8'hAA;
        bus.baudrate_set = 3'd0;
        bus.tx_start     = 1'b1;
        @(posedge clk);
        #3;
        bus.tx_start = 1'b0;
      end
    join
    repeat (5) @(posedge clk);
    #1;
    check("f55 no queued txd", 32'(bus.TxD), 32'd1);
    check("f55 no queued busy", 32'(bus.tx_busy), 32'd0);
    check("f55 no queued state", 32'(dbg_state), 32'd0);
    check("f55 done count", 32'(done_cnt), 32'(d_before + 1));

    // Next frame picks up the new 2400 baud code: start bit lasts 41666 cycles
    launch(8'h0F, 3'd0);
    check_bit(1'b0, 41666, "slow start");
    check("slow bit0 txd", 32'(bus.TxD), 32'd1);
    check("slow bit0 state", 32'(dbg_state), 32'd2);
    reset_abort("slow", done_cnt);

    // Reset in the middle of a data bit at 9600 baud
    launch(8'hC3, 3'd2);
    check_bit(1'b0, 10416, "b9600 start");
    check("b9600 bit0 txd", 32'(bus.TxD), 32'd1);
    check("b9600 bit0 state", 32'(dbg_state), 32'd2);
    repeat (500) @(posedge clk);
    #1;
    reset_abort("b9600", done_cnt);

    // tx_start held high: next frame starts on the edge after the tx_done cycle
    d_before         = done_cnt;
    bus.TxData       = 8'h3C;
    bus.baudrate_set = 3'd7;
    bus.tx_start     = 1'b1;
    @(posedge clk);
    #1;
    run_frame(8'h3C, 434, "b2b0");
    @(posedge clk);
    #1;
    bus.tx_start = 1'b0;
    run_frame(8'h3C, 434, "b2b1");
    repeat (3) @(posedge clk);
    #1;
    check("b2b idle txd", 32'(bus.TxD), 32'd1);
    check("b2b idle busy", 32'(bus.tx_busy), 32'd0);
    check("b2b done count", 32'(done_cnt), 32'(d_before + 2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 SHALL have parameter clk_freq, default 100_000_000, meaning system clock frequency in Hz used for the baud divisor table.
REQ-002 SHALL have port clk  input  1  system clock; all state updates occur on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port baudrate_set  input  3  baud select: 0=2400, 1=4800, 2=9600, 3=19200, 4=38400, 5=57600, 6=115200, 7=230400.
REQ-005 SHALL have port TxData  input  8  byte to transmit.
REQ-006 SHALL have port tx_start  input  1  request to send TxData.
REQ-007 SHALL have port TxD  output  1  serial line; idle high.
REQ-008 SHALL have port tx_busy  output  1  high while a frame is in flight.
REQ-009 SHALL have port tx_done  output  1  one-cycle pulse at frame completion.

Function
REQ-010 SHALL compute the bit period as floor(clk_freq/baud) clocks, held in a 16-bit divisor; at 100 MHz this gives 41666, 20833, 10416, 5208, 2604, 1736, 868, 434.
REQ-011 SHALL implement FSM states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-012 SHALL accept a request only in IDLE: tx_start=1 at edge N latches TxData and baudrate_set, enters START, and drives TxD=0 and tx_busy=1 from edge N.
REQ-013 SHALL hold each bit for exactly one bit period via a divisor counter cleared at every bit boundary.
REQ-014 SHALL drive in START the start bit 0 for one period, then enter DATA.
REQ-015 SHALL send in DATA 8 bits LSB first, using a 3-bit bit index; after bit 7 it enters PARITY if compiled in, else STOP.
REQ-016 SHALL drive in STOP TxD=1 for one period; at its final edge it returns to IDLE, drops tx_busy and pulses tx_done for exactly one cycle.
REQ-017 SHALL ignore tx_start while tx_busy=1; the byte in flight is not corrupted and no request is queued.
REQ-018 SHALL accept a tx_start held high during the tx_done cycle on the next edge, giving back-to-back frames separated by zero idle bits.
REQ-019 SHALL ignore TxData and baudrate_set changes mid-frame; only the latched copies are used.
REQ-020 SHALL drive TxD from a register, so it is glitch-free.

Reset
REQ-021 SHALL, on reset, immediately return to IDLE with TxD=1, tx_busy=0 and tx_done=0, and clear the counters, bit index and latched data.
REQ-022 SHALL abort a frame when reset is asserted mid-frame; after release TxD stays high until a new tx_start.

Configuration
REQ-023 SHALL, when UART_TX_PARITY_EN is defined, insert an even-parity bit (XOR of the 8 latched data bits) between data and stop, for an 11-bit frame.
REQ-024 SHALL, when UART_TX_PARITY_EN is undefined, omit the PARITY state and logic, for a 10-bit frame (8N1).

Verification
REQ-025 SHALL cover: baudrate_set=6, TxData=0x55, tx_start pulse -> TxD 0,1,0,1,0,1,0,1,0,1 each held 868 cycles; tx_busy high 8680 cycles; one tx_done pulse.
REQ-026 SHALL cover: UART_TX_PARITY_EN defined, TxData=0x07, baudrate_set=7 -> parity bit 1 after bit 7; frame lasts 11*434=4774 cycles.
REQ-027 SHALL cover: second tx_start with TxData=0xAA at cycle 2000 of a 0x55 frame -> ignored; only 0x55 is sent; tx_done pulses once.
REQ-028 SHALL cover: reset asserted mid-DATA at baudrate_set=2 -> TxD=1 and tx_busy=0 without waiting for clk; no tx_done.
REQ-029 SHALL cover: tx_start held high continuously with TxData=0x3C -> consecutive frames with no idle gap between the stop bit and the next start bit.
REQ-030 SHALL cover: baudrate_set changed from 6 to 0 mid-frame -> the current frame completes at 868 cycles/bit; the next frame uses 41666 cycles/bit.
